// File: rtl/cpu_trap_ctrl.sv
// Machine-mode trap sequencer: serialises mepc/mcause/mstatus writes through the
// single CSR write port, redirects fetch to mtvec, and performs the mret mstatus restore.
module cpu_trap_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            exception,
  input  logic [1:0]      exception_cause,
  input  logic            mret,
  input  logic            irq,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  output logic            stall,
  output logic            flush,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam logic [1:0] EXCAUSE_ECALL         = 2'd0;
  localparam logic [1:0] EXCAUSE_BREAKPOINT    = 2'd1;
  localparam logic [1:0] EXCAUSE_ILLEGAL_INSTR = 2'd2;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_BREAK   = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_MEXT    = (XLEN'(1) << (XLEN-1)) | XLEN'(11);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT, MRET_ST
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] mstatus_trap, mstatus_ret, vec_base, vec_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // mstatus images for trap entry and mret return
  always_comb begin
    mstatus_trap        = mstatus;
    mstatus_trap[7]     = mstatus[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_ret         = mstatus;
    mstatus_ret[3]      = mstatus[7];
    mstatus_ret[7]      = 1'b1;
    mstatus_ret[12:11]  = 2'b11;
  end

  // Vectored offset only applies to interrupts with mtvec mode 01
  always_comb begin
    vec_base = {mtvec[XLEN-1:2], 2'b00};
    vec_off  = '0;
    if (mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
      vec_off = XLEN'({cause_q[XLEN-2:0], 2'b00});
  end

  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    stall       = 1'b0;
    flush       = 1'b0;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    busy        = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (exception) begin
            stall   = 1'b1;
            flush   = 1'b1;
            epc_d   = pc;
            state_d = W_MEPC;
            case (exception_cause)
              EXCAUSE_ECALL:         cause_d = CAUSE_ECALL;
              EXCAUSE_BREAKPOINT:    cause_d = CAUSE_BREAK;
              EXCAUSE_ILLEGAL_INSTR: cause_d = CAUSE_ILLEGAL;
              default:               cause_d = CAUSE_ILLEGAL;
            endcase
          end else if (irq && mstatus[3]) begin
            stall   = 1'b1;
            flush   = 1'b1;
            epc_d   = pc;
            cause_d = CAUSE_MEXT;
            state_d = W_MEPC;
          end else if (mret) begin
            state_d = MRET_ST;
          end
        end
      end
      W_MEPC: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = epc_q;
        state_d   = W_MCAUSE;
      end
      W_MCAUSE: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = W_MSTATUS;
      end
      W_MSTATUS: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_trap;
        state_d   = REDIRECT;
      end
      REDIRECT: begin
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = vec_base + vec_off;
        state_d     = IDLE;
      end
      MRET_ST: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_ret;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// Directed bench for cpu_trap_ctrl: trap/irq/mret sequences, priority, reset and masking.
module tb_cpu_trap_ctrl;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] C_ECALL = 2'd0;
  localparam logic [1:0] C_BREAK = 2'd1;
  localparam logic [1:0] C_ILL   = 2'd2;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic            exception;
  logic [1:0]      exception_cause;
  logic            mret;
  logic            irq;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic            stall, flush, csr_we, redirect, busy;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata, redirect_pc;

  int tests = 0;
  int failed = 0;

  cpu_trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
    .exception(exception), .exception_cause(exception_cause), .mret(mret),
    .irq(irq), .mstatus(mstatus), .mtvec(mtvec), .stall(stall), .flush(flush),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_csr(input string tag, input logic we, input logic [11:0] a,
                         input logic [XLEN-1:0] d);
    chk({tag, ".we"}, 64'(csr_we), 64'(we));
    chk({tag, ".addr"}, 64'(csr_addr), 64'(a));
    chk({tag, ".data"}, 64'(csr_wdata), 64'(d));
    chk({tag, ".stall"}, 64'(stall), 64'(1));
  endtask

  task automatic idle_inputs();
    instr_valid = 0; exception = 0; irq = 0; mret = 0;
  endtask

  initial begin
    rst = 1; idle_inputs(); pc = '0; exception_cause = C_ECALL;
    mstatus = '0; mtvec = '0;
    tick(); tick();
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.csr_we", 64'(csr_we), 64'(0));
    chk("rst.redirect", 64'(redirect), 64'(0));
    chk("rst.stall", 64'(stall), 64'(0));
    chk("rst.flush", 64'(flush), 64'(0));
    rst = 0;
    tick();

    // ecall
    instr_valid = 1; pc = 32'h100; exception = 1; exception_cause = C_ECALL;
    mtvec = 32'h200; mstatus = 32'h8;
    #1;
    chk("ecall.T.flush", 64'(flush), 64'(1));
    chk("ecall.T.stall", 64'(stall), 64'(1));
    chk("ecall.T.busy", 64'(busy), 64'(0));
    tick(); idle_inputs();
    chk_csr("ecall.mepc", 1, 12'h341, 32'h100);
    chk("ecall.T1.flush", 64'(flush), 64'(0));
    chk("ecall.T1.busy", 64'(busy), 64'(1));
    tick(); chk_csr("ecall.mcause", 1, 12'h342, 32'd11);
    tick(); chk_csr("ecall.mstatus", 1, 12'h300, 32'h1880);
    tick();
    chk("ecall.redir", 64'(redirect), 64'(1));
    chk("ecall.redir_pc", 64'(redirect_pc), 64'(32'h200));
    chk("ecall.redir.we", 64'(csr_we), 64'(0));
    chk("ecall.redir.stall", 64'(stall), 64'(1));
    tick();
    chk("ecall.T5.busy", 64'(busy), 64'(0));
    chk("ecall.T5.stall", 64'(stall), 64'(0));
    chk("ecall.T5.redir_pc", 64'(redirect_pc), 64'(0));

    // vectored interrupt
    instr_valid = 1; irq = 1; mstatus = 32'h8; mtvec = 32'h201; pc = 32'h40;
    #1;
    chk("virq.T.flush", 64'(flush), 64'(1));
    tick(); idle_inputs();
    chk_csr("virq.mepc", 1, 12'h341, 32'h40);
    tick(); chk_csr("virq.mcause", 1, 12'h342, 32'h8000_000B);
    tick(); chk_csr("virq.mstatus", 1, 12'h300, 32'h1880);
    tick();
    chk("virq.redir", 64'(redirect), 64'(1));
    chk("virq.redir_pc", 64'(redirect_pc), 64'(32'h22C));
    tick();
    chk("virq.done.busy", 64'(busy), 64'(0));

    // interrupt masked by MIE=0
    instr_valid = 1; irq = 1; mstatus = 32'h0;
    #1;
    chk("mirq.flush", 64'(flush), 64'(0));
    chk("mirq.stall", 64'(stall), 64'(0));
    tick();
    chk("mirq.busy", 64'(busy), 64'(0));
    chk("mirq.we", 64'(csr_we), 64'(0));
    idle_inputs();

    // mret
    instr_valid = 1; mret = 1; mstatus = 32'h80;
    #1;
    chk("mret.T.flush", 64'(flush), 64'(0));
    chk("mret.T.stall", 64'(stall), 64'(0));
    tick(); idle_inputs();
    chk_csr("mret.mstatus", 1, 12'h300, 32'h1888);
    chk("mret.T1.busy", 64'(busy), 64'(1));
    chk("mret.T1.redir", 64'(redirect), 64'(0));
    tick();
    chk("mret.T2.busy", 64'(busy), 64'(0));
    chk("mret.T2.we", 64'(csr_we), 64'(0));

    // exception beats irq; exceptions ignore vectored mode
    instr_valid = 1; exception = 1; exception_cause = C_ILL; irq = 1;
    mstatus = 32'h8; pc = 32'h44; mtvec = 32'h201;
    tick(); idle_inputs();
    chk_csr("prio.mepc", 1, 12'h341, 32'h44);
    tick(); chk_csr("prio.mcause", 1, 12'h342, 32'd2);
    tick(); tick();
    chk("prio.redir_pc", 64'(redirect_pc), 64'(32'h200));
    tick();

    // irq beats mret
    instr_valid = 1; irq = 1; mret = 1; mstatus = 32'h8; pc = 32'h44;
    #1;
    chk("irqmret.flush", 64'(flush), 64'(1));
    tick(); idle_inputs();
    chk_csr("irqmret.mepc", 1, 12'h341, 32'h44);
    tick(); chk_csr("irqmret.mcause", 1, 12'h342, 32'h8000_000B);
    tick(); tick();
    chk("irqmret.redir_pc", 64'(redirect_pc), 64'(32'h22C));
    tick();

    // reset mid-trap
    instr_valid = 1; exception = 1; exception_cause = C_BREAK; pc = 32'h300;
    mtvec = 32'h200;
    tick(); idle_inputs();
    tick(); chk_csr("rmid.mcause", 1, 12'h342, 32'd3);
    rst = 1;
    #1;
    chk("rmid.we", 64'(csr_we), 64'(0));
    chk("rmid.addr", 64'(csr_addr), 64'(0));
    chk("rmid.busy", 64'(busy), 64'(0));
    tick();
    chk("rmid.T1.we", 64'(csr_we), 64'(0));
    chk("rmid.T1.redir", 64'(redirect), 64'(0));
    tick();
    chk("rmid.T2.redir", 64'(redirect), 64'(0));
    rst = 0;
    instr_valid = 1; exception = 1; exception_cause = C_BREAK; pc = 32'h500;
    tick(); idle_inputs();
    chk_csr("rnew.mepc", 1, 12'h341, 32'h500);
    tick(); chk_csr("rnew.mcause", 1, 12'h342, 32'd3);
    tick(); tick(); tick();
    chk("rnew.busy", 64'(busy), 64'(0));

    // busy masking: exception held through the whole sequence
    instr_valid = 1; exception = 1; exception_cause = C_ECALL; pc = 32'h600;
    mstatus = 32'h0; mtvec = 32'h200;
    tick(); pc = 32'h700;
    chk_csr("mask.mepc", 1, 12'h341, 32'h600);
    tick(); chk_csr("mask.mcause", 1, 12'h342, 32'd11);
    tick(); chk_csr("mask.mstatus", 1, 12'h300, 32'h1800);
    tick();
    chk("mask.redir", 64'(redirect), 64'(1));
    chk("mask.flush", 64'(flush), 64'(0));
    idle_inputs();
    tick();
    chk("mask.T5.busy", 64'(busy), 64'(0));
    chk("mask.T5.we", 64'(csr_we), 64'(0));

    // instr_valid=0 blocks acceptance
    exception = 1; exception_cause = C_ECALL;
    #1;
    chk("nv.flush", 64'(flush), 64'(0));
    tick();
    chk("nv.busy", 64'(busy), 64'(0));
    chk("nv.we", 64'(csr_we), 64'(0));
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cpu_trap_ctrl.md
# cpu_trap_ctrl

- Multi-cycle machine-mode trap sequencer between `cpu_control` and `cpu_csr_file`.
- On a decoded synchronous exception (ecall, ebreak, illegal instruction) or an enabled external interrupt, it:
  - stalls and flushes the front end;
  - writes `mepc`, `mcause` and `mstatus` through the CSR file's single write port, one per cycle;
  - redirects fetch to the trap vector.
- On `mret` it performs the `mstatus` restore write while the datapath takes the `mepc` jump.

## Interface
Parameters:
- `XLEN`, 32, datapath/CSR width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `instr_valid` in 1: decode-stage instruction is real (not a bubble).
- `pc` in XLEN: PC of the decode-stage instruction.
- `exception` in 1: decoder flags a synchronous exception.
- `exception_cause` in 2: `EXCAUSE_*` code from `cpu_csr_file.vh`.
- `mret` in 1: decoder flags `mret`.
- `irq` in 1: level-sensitive machine external interrupt.
- `mstatus` in XLEN: live `mstatus` value from the CSR file.
- `mtvec` in XLEN: live `mtvec` value from the CSR file.
- `stall` out 1: hold PC and the decode register.
- `flush` out 1: kill the decode-stage instruction (suppress `reg_write`, `mem_write`, `csr_write`, `jump`, `branch`).
- `csr_we` out 1: CSR write strobe; has priority over the datapath CSR write.
- `csr_addr` out 12: CSR write address.
- `csr_wdata` out XLEN: CSR write data.
- `redirect` out 1: load PC from `redirect_pc` this cycle.
- `redirect_pc` out XLEN: trap target.
- `busy` out 1: FSM not in IDLE.

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT, MRET_ST.
- Acceptance applies only in IDLE with `instr_valid`=1. Priority: `exception` > interrupt (`irq & mstatus[3]`) > `mret`.
- Trap accepted (cycle T):
  - `stall`=`flush`=1 combinationally in T.
  - Register `epc`←`pc`.
  - Register `cause`:
    - ECALL→11
    - BREAKPOINT→3
    - ILLEGAL_INSTR→2
    - interrupt→`32'h8000_000B`
  - Next state W_MEPC.
- W_MEPC: `csr_we`=1, addr `12'h341`, data `epc`.
- W_MCAUSE: `csr_we`=1, addr `12'h342`, data `cause`.
- W_MSTATUS: `csr_we`=1, addr `12'h300`, data = live `mstatus` with:
  - MPIE[7]←MIE[3]
  - MIE[3]←0
  - MPP[12:11]←2'b11
- REDIRECT: `redirect`=1, `redirect_pc` selected by `mtvec[1:0]`:
  - `01` (vectored) and interrupt: `{mtvec[31:2],2'b00} + 4*cause[30:0]`.
  - Otherwise: `{mtvec[31:2],2'b00}`.
  - Next state IDLE.
- `mret` accepted (cycle T):
  - No stall or flush in T; the datapath jump to `mepc` proceeds.
  - Next state MRET_ST.
- MRET_ST:
  - `csr_we`=1, addr `12'h300`, data = live `mstatus` with MIE[3]←MPIE[7], MPIE[7]←1, MPP←2'b11.
  - `stall`=1 so the next instruction cannot read stale `mstatus`.
  - Next state IDLE.
- Inputs are ignored while `busy`=1. An `irq` that is still asserted is re-evaluated in IDLE.
- `stall`=1 in every non-IDLE state. `flush` is 1 only in the accept cycle of a trap.
- `csr_addr`/`csr_wdata` = 0 whenever `csr_we`=0. `redirect_pc` = 0 whenever `redirect`=0.

## Timing
- Reset:
  - State IDLE; `epc`, `cause` = 0.
  - All outputs 0, except `stall`/`flush`, which follow the combinational IDLE decode.
- Reset asserted mid-sequence: immediate return to IDLE; no further CSR writes or redirect.
- Trap latency:
  - Accept cycle T.
  - CSR writes in T+1, T+2, T+3.
  - `redirect` in T+4.
  - `stall` high T..T+4; the first handler fetch is at T+5.
- `mret`: one stall cycle at T+1; total busy 1 cycle.
- All state, `epc` and `cause` update on the rising edge of `clk`. Outputs are decoded from state, except the IDLE `stall`/`flush`.
- Simultaneous `exception`, `irq` and `mret`: exception wins. `irq` plus `mret`: interrupt wins, `mret` is flushed and `mepc`=PC of the `mret`.
- `instr_valid`=0 in IDLE: nothing accepted, including a pending interrupt.

## Test plan
- **ecall:** `pc`=`0x100`, `exception`=1, cause ECALL, `mtvec`=`0x200`, `mstatus`=`0x8` → T: `flush`=1. Then:
  - T+1: `0x341`←`0x100`.
  - T+2: `0x342`←11.
  - T+3: `0x300`←`0x1880`.
  - T+4: `redirect`=1, `redirect_pc`=`0x200`.
  - `busy` low at T+5.
- **Vectored interrupt:** `irq`=1, `mstatus`=`0x8`, `mtvec`=`0x201`, `pc`=`0x40` → `mcause` write `0x8000000B`, `redirect_pc`=`0x22C`. Same stimulus with `mstatus`=0 → no trap.
- **mret:** `mret`=1, `mstatus`=`0x80` → T+1: `csr_we`, `0x300`←`0x1888`, `stall`=1. T+2: IDLE.
- **Priority:** `exception`(ILLEGAL) + `irq` + `mstatus`=`0x8`, `pc`=`0x44` → `mcause` write 2, `mepc` write `0x44`. `irq` + `mret` → `mcause`=`0x8000000B`, `mepc`=`0x44`.
- **Reset mid-trap:** assert `rst` in W_MCAUSE → outputs 0 immediately, no `0x300` write, no `redirect`. Release → IDLE accepts a new ebreak (`mcause` 3).
- **Busy masking:** pulse `exception` during W_MEPC..REDIRECT → exactly one trap sequence. `instr_valid`=0 with `exception`=1 → no action.
